// File: rtl/simd_perm_pkg.sv
// Shared types for the SIMD permutation unit: mode encoding and default-geometry helpers.
package simd_perm_pkg;

    typedef enum logic [2:0] {
        ModePass   = 3'd0,
        ModeGather = 3'd1,
        ModeRot    = 3'd2,
        ModeRev    = 3'd3,
        ModeZip    = 3'd4,
        ModeUnzip  = 3'd5,
        ModeBcast  = 3'd6,
        ModeRsvd   = 3'd7
    } perm_mode_e;

    localparam int DefLanes = 8;
    localparam int DefBanks = 8;
    localparam int DefElemW = 64;
    localparam int DefIdxW  = 16;
    localparam int NumElems = DefLanes * DefBanks;
    localparam int ElemIdxW = $clog2(NumElems);

    typedef logic [DefElemW-1:0] elem_t;
    typedef logic [NumElems-1:0][DefIdxW-1:0] idx_vec_t;

    // Reset contents of the index register for the default geometry.
    function automatic idx_vec_t identity_idx();
        idx_vec_t v;
        for (int e = 0; e < NumElems; e++) begin
            v[e] = DefIdxW'(e);
        end
        return v;
    endfunction

endpackage

// File: rtl/simd_perm_if.sv
// Beat-level bus of the permutation unit: input beat channel, output beat channel, status.
interface simd_perm_if #(
    parameter int Elems = 64,
    parameter int ElemW = 64,
    parameter int IdxW  = 16
);
    import simd_perm_pkg::*;

    logic                   in_valid_i;
    logic                   in_ready_o;
    logic                   in_sel_idx_i;
    perm_mode_e             in_mode_i;
    logic [IdxW-1:0]        in_amt_i;
    logic [Elems*ElemW-1:0] in_data_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [Elems*ElemW-1:0] out_data_o;
    logic                   out_err_o;
    logic                   idx_loaded_o;

    modport master (
        output in_valid_i, in_sel_idx_i, in_mode_i, in_amt_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_err_o, idx_loaded_o
    );

    modport slave (
        input  in_valid_i, in_sel_idx_i, in_mode_i, in_amt_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_err_o, idx_loaded_o
    );

endinterface

// File: rtl/simd_perm_stage.sv
// One elastic valid/ready register slice; accepts whenever empty or draining downstream.
module simd_perm_stage #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inValid,
    output logic         inReady,
    input  logic [W-1:0] inData,
    output logic         outValid,
    input  logic         outReady,
    output logic [W-1:0] outData
);

    assign inReady = !outValid || outReady;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outValid <= 1'b0;
            outData  <= '0;
        end else if (inReady) begin
            outValid <= inValid;
            if (inValid) begin
                outData <= inData;
            end
        end
    end

endmodule

// File: rtl/simd_perm_unit.sv
// SIMD permutation engine: mode-selected crossbar feeding a NumStages-deep elastic pipeline.
// Optional macro SIMD_PERM_ZERO_OOB_EN: out-of-range indices yield zero instead of wrapping.
module simd_perm_unit
    import simd_perm_pkg::*;
#(
    parameter int NumLanes  = 8,
    parameter int NumBanks  = 8,
    parameter int ElemW     = 64,
    parameter int IdxW      = 16,
    parameter int NumStages = 2
) (
    input logic       clk_i,
    input logic       rst_i,
    simd_perm_if.slave bus
);

    localparam int Elems = NumLanes * NumBanks;
    localparam int EIdxW = (Elems > 1) ? $clog2(Elems) : 1;
    localparam int LdW   = (IdxW < ElemW) ? IdxW : ElemW;
    localparam int PayW  = Elems * ElemW + 1;

`ifdef SIMD_PERM_ZERO_OOB_EN
    localparam bit ZeroOob = 1'b1;
`else
    localparam bit ZeroOob = 1'b0;
`endif

    if (NumStages != 1 && NumStages != 2) begin : gBadStages
        $error("simd_perm_unit: NumStages must be 1 or 2");
    end
    if (IdxW < EIdxW) begin : gBadIdxW
        $error("simd_perm_unit: IdxW too narrow for NumElems");
    end

    logic [ElemW-1:0]       inElem   [Elems];
    logic [ElemW-1:0]       permElem [Elems];
    logic [IdxW-1:0]        idxReg   [Elems];
    logic [Elems*ElemW-1:0] permFlat;
    logic                   permErr;
    logic [EIdxW-1:0]       rotAmt;
    logic                   idxLoaded;
    logic                   acceptIdx;
    logic                   stageInValid;
    logic [PayW-1:0]        stageInData;

    for (genvar e = 0; e < Elems; e++) begin : gFlat
        assign inElem[e] = bus.in_data_i[e*ElemW +: ElemW];
        assign permFlat[e*ElemW +: ElemW] = permElem[e];
    end

    function automatic logic isOob(input logic [IdxW-1:0] idx);
        return {1'b0, idx} >= (IdxW+1)'(Elems);
    endfunction

    function automatic logic [EIdxW-1:0] wrapIdx(input logic [IdxW-1:0] idx);
        return EIdxW'({1'b0, idx} % (IdxW+1)'(Elems));
    endfunction

    function automatic logic [EIdxW-1:0] addMod(input int e, input logic [EIdxW-1:0] amt);
        int s;
        s = e + int'(amt);
        if (s >= Elems) s = s - Elems;
        return EIdxW'(s);
    endfunction

    // Crossbar: every mode starts from PASS and overrides the element routing it needs.
    always_comb begin
        permErr = (bus.in_mode_i == ModeRsvd);
        rotAmt  = EIdxW'({1'b0, bus.in_amt_i} % (IdxW+1)'(Elems));
        for (int e = 0; e < Elems; e++) begin
            permElem[e] = inElem[e];
        end
        case (bus.in_mode_i)
            ModeGather: begin
                for (int e = 0; e < Elems; e++) begin
                    permElem[e] = inElem[wrapIdx(idxReg[e])];
                    if (isOob(idxReg[e])) begin
                        permErr = 1'b1;
                        if (ZeroOob) permElem[e] = '0;
                    end
                end
            end
            ModeRot: begin
                for (int e = 0; e < Elems; e++) begin
                    permElem[e] = inElem[addMod(e, rotAmt)];
                end
            end
            ModeRev: begin
                for (int e = 0; e < Elems; e++) begin
                    permElem[e] = inElem[Elems-1-e];
                end
            end
            ModeZip: begin
                for (int k = 0; k < Elems/2; k++) begin
                    permElem[2*k]   = inElem[k];
                    permElem[2*k+1] = inElem[k+Elems/2];
                end
            end
            ModeUnzip: begin
                for (int k = 0; k < Elems/2; k++) begin
                    permElem[k]         = inElem[2*k];
                    permElem[k+Elems/2] = inElem[2*k+1];
                end
            end
            ModeBcast: begin
                for (int e = 0; e < Elems; e++) begin
                    permElem[e] = inElem[wrapIdx(idxReg[0])];
                    if (ZeroOob && isOob(idxReg[0])) permElem[e] = '0;
                end
                if (isOob(idxReg[0])) permErr = 1'b1;
            end
            default: ;
        endcase
    end

    // Index-load beats bypass the pipeline but still wait for a free head slot.
    assign acceptIdx = bus.in_valid_i && bus.in_sel_idx_i && bus.in_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int e = 0; e < Elems; e++) begin
                idxReg[e] <= IdxW'(e);
            end
            idxLoaded <= 1'b0;
        end else if (acceptIdx) begin
            for (int e = 0; e < Elems; e++) begin
                idxReg[e] <= IdxW'(bus.in_data_i[e*ElemW +: LdW]);
            end
            idxLoaded <= 1'b1;
        end
    end

    assign stageInValid = bus.in_valid_i && !bus.in_sel_idx_i;
    assign stageInData  = {permErr, permFlat};

    for (genvar s = 0; s < NumStages; s++) begin : gStage
        logic            upValid, upReady, dnValid, dnReady;
        logic [PayW-1:0] upData, dnData;

        if (s == 0) begin : gHead
            assign upValid = stageInValid;
            assign upData  = stageInData;
        end else begin : gLink
            assign upValid = gStage[s-1].dnValid;
            assign upData  = gStage[s-1].dnData;
        end

        if (s == NumStages - 1) begin : gTail
            assign dnReady = bus.out_ready_i;
        end else begin : gNext
            assign dnReady = gStage[s+1].upReady;
        end

        simd_perm_stage #(.W(PayW)) uStage (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .inValid  (upValid),
            .inReady  (upReady),
            .inData   (upData),
            .outValid (dnValid),
            .outReady (dnReady),
            .outData  (dnData)
        );
    end

    assign bus.in_ready_o                  = gStage[0].upReady;
    assign bus.out_valid_o                 = gStage[NumStages-1].dnValid;
    assign {bus.out_err_o, bus.out_data_o} = gStage[NumStages-1].dnData;
    assign bus.idx_loaded_o                = idxLoaded;

endmodule

// File: tb/tb_simd_perm_unit.sv
// Directed scoreboard bench for simd_perm_unit in a 2x2 lane/bank, 8-bit element build.
module tb_simd_perm_unit;
    import simd_perm_pkg::*;

    localparam int NL = 2;
    localparam int NB = 2;
    localparam int EW = 8;
    localparam int IW = 8;
    localparam int NS = 2;
    localparam int NE = NL * NB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          nAssert = 0;
    int          nFail = 0;
    logic [32:0] sb[$];
    logic        holdReady = 1'b1;
    logic        bpEn = 1'b0;
    int          bpCnt = 0;
    logic [3:0]  bpPattern = 4'b1001;
    logic        sawStall = 1'b0;
    logic        prevStall = 1'b0;
    logic [32:0] prevOut = '0;

    simd_perm_if #(.Elems(NE), .ElemW(EW), .IdxW(IW)) bus ();

    simd_perm_unit #(
        .NumLanes(NL), .NumBanks(NB), .ElemW(EW), .IdxW(IW), .NumStages(NS)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Downstream ready: either a held level or the repeating 1,0,0,1 pattern.
    always @(posedge clk) begin
        #1;
        bus.out_ready_i = bpEn ? bpPattern[bpCnt % 4] : holdReady;
        if (bpEn) bpCnt++;
    end

    task automatic checkOutput(input string tag, input logic [32:0] got, input logic [32:0] exp);
        nAssert++;
        assert (got === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard pops on handshake, stall stability, input-stall detection.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid_o && prevStall)
                checkOutput("stallStable", {bus.out_err_o, bus.out_data_o}, prevOut);
            if (bus.in_valid_i && !bus.in_ready_o) sawStall = 1'b1;
            if (bus.out_valid_o && bus.out_ready_i) begin
                checkOutput("spurious", 33'(sb.size() > 0), 33'd1);
                if (sb.size() > 0) checkOutput("beat", {bus.out_err_o, bus.out_data_o}, sb.pop_front());
            end
            prevStall = bus.out_valid_o && !bus.out_ready_i;
            prevOut   = {bus.out_err_o, bus.out_data_o};
        end else begin
            prevStall = 1'b0;
        end
    end

    task automatic applyStimulus(input logic sel, input logic [2:0] mode, input logic [IW-1:0] amt,
                                 input logic [31:0] data, input logic expErr, input logic [31:0] expData);
        int   waitCycles = 0;
        logic ok = 1'b0;
        bus.in_valid_i   = 1'b1;
        bus.in_sel_idx_i = sel;
        bus.in_mode_i    = perm_mode_e'(mode);
        bus.in_amt_i     = amt;
        bus.in_data_i    = data;
        do begin
            @(negedge clk);
            ok = bus.in_ready_o;
            if (ok && !sel) sb.push_back({expErr, expData});
            @(posedge clk);
            #1;
            waitCycles++;
        end while (!ok && waitCycles < 50);
        checkOutput("acceptTimeout", 33'(ok), 33'd1);
        bus.in_valid_i = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput(tag, 33'(sb.size()), 33'd0);
    endtask

    initial begin
        logic [31:0] oobExp;
`ifdef SIMD_PERM_ZERO_OOB_EN
        oobExp = 32'h00A1A1A1;
`else
        oobExp = 32'hD4A1A1A1;
`endif
        bus.in_valid_i   = 1'b0;
        bus.in_sel_idx_i = 1'b0;
        bus.in_mode_i    = ModePass;
        bus.in_amt_i     = '0;
        bus.in_data_i    = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstValid", 33'(bus.out_valid_o), 33'd0);
        checkOutput("rstData", {bus.out_err_o, bus.out_data_o}, 33'd0);
        checkOutput("rstIdxLoaded", 33'(bus.idx_loaded_o), 33'd0);
        checkOutput("rstInReady", 33'(bus.in_ready_o), 33'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] PASS mode and latency");
        applyStimulus(1'b0, 3'd0, 8'd0, 32'h03020100, 1'b0, 32'h03020100);
        checkOutput("latencyEarly", 33'(bus.out_valid_o), 33'd0);
        @(posedge clk);
        #1;
        checkOutput("latencyValid", 33'(bus.out_valid_o), 33'd1);
        waitDrain("drainPass");
        checkOutput("idxLoadedPre", 33'(bus.idx_loaded_o), 33'd0);

        $display("[TB] Index load and permute modes");
        applyStimulus(1'b1, 3'd0, 8'd0, 32'h00000301, 1'b0, 32'h0);
        checkOutput("idxLoaded", 33'(bus.idx_loaded_o), 33'd1);
        applyStimulus(1'b0, 3'd1, 8'd0, 32'hD4C3B2A1, 1'b0, 32'hA1A1D4B2);
        applyStimulus(1'b0, 3'd2, 8'd1, 32'hD4C3B2A1, 1'b0, 32'hA1D4C3B2);
        applyStimulus(1'b0, 3'd2, 8'd5, 32'hD4C3B2A1, 1'b0, 32'hA1D4C3B2);
        applyStimulus(1'b0, 3'd3, 8'd0, 32'hD4C3B2A1, 1'b0, 32'hA1B2C3D4);
        applyStimulus(1'b0, 3'd4, 8'd0, 32'hD4C3B2A1, 1'b0, 32'hD4B2C3A1);
        applyStimulus(1'b0, 3'd5, 8'd0, 32'hD4C3B2A1, 1'b0, 32'hD4B2C3A1);
        applyStimulus(1'b0, 3'd6, 8'd0, 32'hD4C3B2A1, 1'b0, 32'hB2B2B2B2);
        waitDrain("drainModes");

        $display("[TB] Out-of-range index and reserved mode");
        applyStimulus(1'b1, 3'd0, 8'd0, 32'h07000000, 1'b0, 32'h0);
        applyStimulus(1'b0, 3'd1, 8'd0, 32'hD4C3B2A1, 1'b1, oobExp);
        applyStimulus(1'b0, 3'd6, 8'd0, 32'hD4C3B2A1, 1'b0, 32'hA1A1A1A1);
        applyStimulus(1'b0, 3'd7, 8'd0, 32'hD4C3B2A1, 1'b1, 32'hD4C3B2A1);
        waitDrain("drainOob");

        $display("[TB] Backpressure stream");
        sawStall = 1'b0;
        bpEn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 3'd0, 8'd0, 32'h11223300 + 32'(i), 1'b0, 32'h11223300 + 32'(i));
        end
        waitDrain("drainBackpressure");
        bpEn = 1'b0;
        checkOutput("inReadyLow", 33'(sawStall), 33'd1);

        $display("[TB] Reset with beats in flight");
        holdReady = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 3'd0, 8'd0, 32'h0A0B0C0D, 1'b0, 32'h0A0B0C0D);
        applyStimulus(1'b0, 3'd0, 8'd0, 32'h01020304, 1'b0, 32'h01020304);
        @(posedge clk);
        #1;
        checkOutput("inFlight", 33'(bus.out_valid_o), 33'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncValid", 33'(bus.out_valid_o), 33'd0);
        checkOutput("asyncIdxLoaded", 33'(bus.idx_loaded_o), 33'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        holdReady = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 3'd1, 8'd0, 32'hD4C3B2A1, 1'b0, 32'hD4C3B2A1);
        waitDrain("drainIdentity");

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
